// File: rtl/ex_stage_alu.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_alu
// Purpose  : Execute stage behind the ID/EX register. Produces a registered ALU
//            result and forwards control bits and destination index to EX/MEM.
// Config   : EX_MUL_EN enables the iterative shift-add multiplier on op 10.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_alu #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 14,
  parameter int CTRL_W = 4,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [OPC_W-1:0]  opcode_in,
  input  logic [DATA_W-1:0] rgS1_data_in,
  input  logic [DATA_W-1:0] rgS2_data_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [REG_W-1:0]  rgD_index_in,
  output logic              stall,
  output logic              valid_out,
  output logic [DATA_W-1:0] result_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [REG_W-1:0]  rgD_index_out
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_and  = 4'd2;
  localparam logic [3:0] c_op_or   = 4'd3;
  localparam logic [3:0] c_op_xor  = 4'd4;
  localparam logic [3:0] c_op_sll  = 4'd5;
  localparam logic [3:0] c_op_srl  = 4'd6;
  localparam logic [3:0] c_op_sra  = 4'd7;
  localparam logic [3:0] c_op_slt  = 4'd8;
  localparam logic [3:0] c_op_sltu = 4'd9;
  localparam logic [3:0] c_op_mul  = 4'd10;

  logic [3:0]        w_op;
  logic [SH_W-1:0]   w_shamt;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_accept_alu;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_result;
  logic [CTRL_W-1:0] w_mul_ctrl;
  logic [REG_W-1:0]  w_mul_idx;
  logic              w_unused_opc;

  assign w_op         = opcode_in[3:0];
  assign w_shamt      = rgS2_data_in[SH_W-1:0];
  assign w_unused_opc = ^opcode_in[OPC_W-1:4];

  // Single-cycle datapath; op 10 yields 0 here because the multiplier
  // (when built) bypasses this mux entirely.
  always_comb begin
    w_alu_result = '0;
    case (w_op)
      c_op_add:  w_alu_result = rgS1_data_in + rgS2_data_in;
      c_op_sub:  w_alu_result = rgS1_data_in - rgS2_data_in;
      c_op_and:  w_alu_result = rgS1_data_in & rgS2_data_in;
      c_op_or:   w_alu_result = rgS1_data_in | rgS2_data_in;
      c_op_xor:  w_alu_result = rgS1_data_in ^ rgS2_data_in;
      c_op_sll:  w_alu_result = rgS1_data_in << w_shamt;
      c_op_srl:  w_alu_result = rgS1_data_in >> w_shamt;
      c_op_sra:  w_alu_result = $signed(rgS1_data_in) >>> w_shamt;
      c_op_slt:  w_alu_result = {{(DATA_W-1){1'b0}},
                                 ($signed(rgS1_data_in) < $signed(rgS2_data_in))};
      c_op_sltu: w_alu_result = {{(DATA_W-1){1'b0}}, (rgS1_data_in < rgS2_data_in)};
      c_op_mul:  w_alu_result = '0;
      default:   w_alu_result = rgS2_data_in;
    endcase
  end

`ifdef EX_MUL_EN
  localparam int               CNT_W    = SH_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_mul  = 1'b1;

  logic [0:0]        state_q,    state_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [DATA_W-1:0] acc_q,      acc_d;
  logic [DATA_W-1:0] a_sh_q,     a_sh_d;
  logic [DATA_W-1:0] b_sh_q,     b_sh_d;
  logic [CTRL_W-1:0] mul_ctrl_q, mul_ctrl_d;
  logic [REG_W-1:0]  mul_idx_q,  mul_idx_d;
  logic              w_is_mul;
  logic              w_stall;
  logic [DATA_W-1:0] w_acc_next;

  assign w_is_mul   = (w_op == c_op_mul);
  assign w_acc_next = acc_q + (b_sh_q[0] ? a_sh_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= c_st_idle;
      count_q    <= '0;
      acc_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      mul_ctrl_q <= '0;
      mul_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      mul_ctrl_q <= mul_ctrl_d;
      mul_idx_q  <= mul_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    mul_ctrl_d = mul_ctrl_q;
    mul_idx_d  = mul_idx_q;
    case (state_q)
      c_st_idle: begin
        if (valid_in && w_is_mul && !flush) begin
          state_d    = c_st_mul;
          count_d    = '0;
          acc_d      = '0;
          a_sh_d     = rgS1_data_in;
          b_sh_d     = rgS2_data_in;
          mul_ctrl_d = control_in;
          mul_idx_d  = rgD_index_in;
        end
      end
      c_st_mul: begin
        if (flush) begin
          state_d = c_st_idle;
          count_d = '0;
        end else begin
          acc_d  = w_acc_next;
          a_sh_d = a_sh_q << 1;
          b_sh_d = b_sh_q >> 1;
          if (count_q == CNT_LAST) begin
            state_d = c_st_idle;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = c_st_idle;
        count_d = '0;
      end
    endcase
  end

  // Stall is released in the final iteration so ID/EX advances on the
  // same edge that captures the product.
  always_comb begin
    w_stall      = 1'b0;
    w_mul_done   = 1'b0;
    w_accept_alu = 1'b0;
    case (state_q)
      c_st_idle: begin
        w_stall      = valid_in && w_is_mul && !flush;
        w_accept_alu = valid_in && !w_is_mul && !flush;
      end
      c_st_mul: begin
        w_stall    = !flush && (count_q != CNT_LAST);
        w_mul_done = !flush && (count_q == CNT_LAST);
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  assign stall        = w_stall && !reset;
  assign w_mul_result = w_acc_next;
  assign w_mul_ctrl   = mul_ctrl_q;
  assign w_mul_idx    = mul_idx_q;
`else
  assign stall        = 1'b0;
  assign w_accept_alu = valid_in && !flush;
  assign w_mul_done   = 1'b0;
  assign w_mul_result = '0;
  assign w_mul_ctrl   = '0;
  assign w_mul_idx    = '0;
`endif

  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] result_q,  result_d;
  logic [CTRL_W-1:0] control_q, control_d;
  logic [REG_W-1:0]  rgd_idx_q, rgd_idx_d;

  always_comb begin
    valid_d   = 1'b0;
    result_d  = result_q;
    control_d = control_q;
    rgd_idx_d = rgd_idx_q;
    if (w_mul_done) begin
      valid_d   = 1'b1;
      result_d  = w_mul_result;
      control_d = w_mul_ctrl;
      rgd_idx_d = w_mul_idx;
    end else if (w_accept_alu) begin
      valid_d   = 1'b1;
      result_d  = w_alu_result;
      control_d = control_in;
      rgd_idx_d = rgD_index_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      control_q <= '0;
      rgd_idx_q <= '0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      control_q <= control_d;
      rgd_idx_q <= rgd_idx_d;
    end
  end

  assign valid_out     = valid_q;
  assign result_out    = result_q;
  assign control_out   = control_q;
  assign rgD_index_out = rgd_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_alu
// Purpose  : Directed self-checking bench for ex_stage_alu (both EX_MUL_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_alu;

  localparam int DATA_W = 32;
  localparam int OPC_W  = 14;
  localparam int CTRL_W = 4;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic              flush;
  logic [OPC_W-1:0]  opcode_in;
  logic [DATA_W-1:0] rgS1_data_in;
  logic [DATA_W-1:0] rgS2_data_in;
  logic [CTRL_W-1:0] control_in;
  logic [REG_W-1:0]  rgD_index_in;
  logic              stall;
  logic              valid_out;
  logic [DATA_W-1:0] result_out;
  logic [CTRL_W-1:0] control_out;
  logic [REG_W-1:0]  rgD_index_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_stage_alu #(
    .DATA_W(DATA_W), .OPC_W(OPC_W), .CTRL_W(CTRL_W), .REG_W(REG_W)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
    .opcode_in(opcode_in), .rgS1_data_in(rgS1_data_in), .rgS2_data_in(rgS2_data_in),
    .control_in(control_in), .rgD_index_in(rgD_index_in), .stall(stall),
    .valid_out(valid_out), .result_out(result_out), .control_out(control_out),
    .rgD_index_out(rgD_index_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upper opcode bits carry junk to show they are ignored.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctrl, input logic [4:0] idx);
    valid_in     = 1'b1;
    flush        = 1'b0;
    opcode_in    = {10'h2A5, op};
    rgS1_data_in = a;
    rgS2_data_in = b;
    control_in   = ctrl;
    rgD_index_in = idx;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b0; flush = 1'b0; opcode_in = '0;
    rgS1_data_in = '0; rgS2_data_in = '0; control_in = '0; rgD_index_in = '0;
    step();
    vectors++;
    if ({valid_out, result_out, control_out, rgD_index_out, stall} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b r=%h c=%h i=%h s=%b, want all 0",
               valid_out, result_out, control_out, rgD_index_out, stall);
    end
    reset = 1'b0;
    drive(4'd0, 32'd2, 32'd3, 4'h5, 5'd7);
    step();
    vectors++;
    if (valid_out !== 1'b1 || result_out !== 32'd5) begin
      miscompares++;
      $display("FAIL pre_reset_add: got v=%b r=%h, want v=1 r=00000005", valid_out, result_out);
    end
`ifdef EX_MUL_EN
    drive(4'd10, 32'd9, 32'd9, 4'h3, 5'd2);
`endif
    step();
    step();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({valid_out, result_out, control_out, rgD_index_out, stall} !== '0) begin
      miscompares++;
      $display("FAIL reset_midrun: got v=%b r=%h c=%h i=%h s=%b, want all 0",
               valid_out, result_out, control_out, rgD_index_out, stall);
    end
    valid_in = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < DATA_W + 3; k++) begin
      step();
      vectors++;
      if (valid_out !== 1'b0 || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet[%0d]: got v=%b s=%b, want v=0 s=0", k, valid_out, stall);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops  [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                               4'd8, 4'd9, 4'd11, 4'd15};
    logic [31:0] av   [12] = '{32'hFFFF_FFFF, 32'h0, 32'hF0F0_1234, 32'hF000_0000,
                               32'hFFFF_0000, 32'h1, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 32'h0};
    logic [31:0] bv   [12] = '{32'h1, 32'h1, 32'h0FF0_FF00, 32'h0000_000F,
                               32'h0F0F_0F0F, 32'h24, 32'd31, 32'd4,
                               32'h1, 32'h1, 32'hCAFE_BABE, 32'h1234};
    logic [31:0] expv [12] = '{32'h0, 32'hFFFF_FFFF, 32'h00F0_1200, 32'hF000_000F,
                               32'hF0F0_0F0F, 32'h10, 32'h1, 32'hF800_0000,
                               32'h1, 32'h0, 32'hCAFE_BABE, 32'h1234};
    for (int i = 0; i < 12; i++) begin
      drive(ops[i], av[i], bv[i], 4'(i), 5'(i + 3));
      #1;
      vectors++;
      if (stall !== 1'b0) begin
        miscompares++;
        $display("FAIL alu_stall[op%0d]: got %b want 0", ops[i], stall);
      end
      step();
      vectors++;
      if (valid_out !== 1'b1 || result_out !== expv[i] ||
          control_out !== 4'(i) || rgD_index_out !== 5'(i + 3)) begin
        miscompares++;
        $display("FAIL alu[op%0d]: got v=%b r=%h c=%h i=%0d, want v=1 r=%h c=%h i=%0d",
                 ops[i], valid_out, result_out, control_out, rgD_index_out,
                 expv[i], 4'(i), i + 3);
      end
    end
    valid_in = 1'b0;
    step();
    vectors++;
    if (valid_out !== 1'b0 || result_out !== 32'h1234) begin
      miscompares++;
      $display("FAIL alu_hold: got v=%b r=%h, want v=0 r=00001234", valid_out, result_out);
    end
  endtask

  task automatic test_flush_idle();
    drive(4'd0, 32'd100, 32'd1, 4'hA, 5'd9);
    flush = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_stall: got %b want 0", stall);
    end
    step();
    flush = 1'b0;
    valid_in = 1'b0;
    vectors++;
    if (valid_out !== 1'b0 || result_out !== 32'h1234 || control_out !== 4'd11) begin
      miscompares++;
      $display("FAIL flush_idle: got v=%b r=%h c=%h, want v=0 r=00001234 c=b",
               valid_out, result_out, control_out);
    end
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    drive(4'd10, 32'd7, 32'd6, 4'hC, 5'd17);
    for (int k = 0; k < DATA_W; k++) begin
      #1;
      vectors++;
      if (stall !== 1'b1 || valid_out !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_busy[T+%0d]: got s=%b v=%b, want s=1 v=0", k, stall, valid_out);
      end
      step();
    end
    #1;
    vectors++;
    if (stall !== 1'b0 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_last: got s=%b v=%b, want s=0 v=0", stall, valid_out);
    end
    step();
    vectors++;
    if (valid_out !== 1'b1 || result_out !== 32'd42 ||
        control_out !== 4'hC || rgD_index_out !== 5'd17) begin
      miscompares++;
      $display("FAIL mul_result: got v=%b r=%h c=%h i=%0d, want v=1 r=0000002a c=c i=17",
               valid_out, result_out, control_out, rgD_index_out);
    end
    drive(4'd0, 32'd10, 32'd20, 4'h1, 5'd4);
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_next_stall: got %b want 0", stall);
    end
    step();
    vectors++;
    if (valid_out !== 1'b1 || result_out !== 32'd30 || control_out !== 4'h1) begin
      miscompares++;
      $display("FAIL mul_next_add: got v=%b r=%h c=%h, want v=1 r=0000001e c=1",
               valid_out, result_out, control_out);
    end
  endtask

  task automatic test_mul_wrap_flush();
    drive(4'd10, 32'h0001_0000, 32'h0001_0000, 4'h2, 5'd8);
    for (int k = 0; k <= DATA_W; k++) step();
    vectors++;
    if (valid_out !== 1'b1 || result_out !== 32'h0) begin
      miscompares++;
      $display("FAIL mul_wrap: got v=%b r=%h, want v=1 r=00000000", valid_out, result_out);
    end
    drive(4'd10, 32'd5, 32'd9, 4'h6, 5'd3);
    for (int k = 0; k < 5; k++) step();
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_pre_flush_stall: got %b want 1", stall);
    end
    valid_in = 1'b0;
    flush = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_flush_stall: got %b want 0", stall);
    end
    step();
    flush = 1'b0;
    for (int k = 0; k < DATA_W + 2; k++) begin
      vectors++;
      if (valid_out !== 1'b0 || stall !== 1'b0 || result_out !== 32'h0) begin
        miscompares++;
        $display("FAIL mul_aborted[%0d]: got v=%b s=%b r=%h, want v=0 s=0 r=00000000",
                 k, valid_out, stall, result_out);
      end
      step();
    end
    drive(4'd0, 32'd1, 32'd2, 4'h9, 5'd30);
    step();
    valid_in = 1'b0;
    vectors++;
    if (valid_out !== 1'b1 || result_out !== 32'd3 || rgD_index_out !== 5'd30) begin
      miscompares++;
      $display("FAIL after_flush_add: got v=%b r=%h i=%0d, want v=1 r=00000003 i=30",
               valid_out, result_out, rgD_index_out);
    end
  endtask
`else
  task automatic test_mul_disabled();
    drive(4'd10, 32'd3, 32'd4, 4'hE, 5'd21);
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL nomul_stall: got %b want 0", stall);
    end
    step();
    valid_in = 1'b0;
    vectors++;
    if (valid_out !== 1'b1 || result_out !== 32'h0 ||
        control_out !== 4'hE || rgD_index_out !== 5'd21) begin
      miscompares++;
      $display("FAIL nomul_result: got v=%b r=%h c=%h i=%0d, want v=1 r=00000000 c=e i=21",
               valid_out, result_out, control_out, rgD_index_out);
    end
    step();
    vectors++;
    if (valid_out !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL nomul_after: got v=%b s=%b, want v=0 s=0", valid_out, stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_ops();
    test_flush_idle();
`ifdef EX_MUL_EN
    test_mul();
    test_mul_wrap_flush();
`else
    test_mul_disabled();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
